// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle datapath: fetch/decode/execute sequencing,
// mem_ready-stretched memory states, retired-instruction counter and sticky illegal flag.
module multicycle_control (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [5:0]                opcode,
   input  logic                      mem_ready,
   output logic                      pc_write,
   output logic                      pc_write_cond,
   output logic                      i_or_d,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic                      ir_write,
   output logic                      mem_to_reg,
   output logic                      reg_dst,
   output logic                      reg_write,
   output logic                      alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [1:0]                alu_op,
   output logic [1:0]                pc_source,
   output logic [3:0]                state,
   output logic                      illegal_op,
   output logic [15:0]               instr_retired
);

   localparam int unsigned ST_W  = 4;
   localparam int unsigned CNT_W = 16;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   logic [ST_W-1:0]  r_state;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;
   logic [ST_W-1:0]  w_next;
   logic             w_set_illegal;
   logic             w_retire;

   // State, sticky illegal flag and retirement counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_set_illegal) r_illegal <= 1'b1;
         if (w_retire)      r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Next-state logic; retirement is any completing transition back to FETCH
   always_comb begin
      w_next        = S_FETCH;
      w_set_illegal = 1'b0;
      w_retire      = 1'b0;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTE;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEXEC;
               OP_J:         w_next = S_JUMP;
               default: begin
                  w_next        = S_FETCH;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:    w_retire = 1'b1;
         S_MEMWR: begin
            w_next   = mem_ready ? S_FETCH : S_MEMWR;
            w_retire = mem_ready;
         end
         S_EXECUTE:  w_next = S_ALUWB;
         S_ALUWB:    w_retire = 1'b1;
         S_BRANCH:   w_retire = 1'b1;
         S_ADDIEXEC: w_next = S_ADDIWB;
         S_ADDIWB:   w_retire = 1'b1;
         S_JUMP:     w_retire = 1'b1;
         default:    w_next = S_FETCH;
      endcase
   end

   // Moore output decode; FETCH strobes gated by mem_ready, strobes killed under reset
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB:   reg_write = 1'b1;
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
      end
   end

   assign state         = r_state;
   assign illegal_op    = r_illegal;
   assign instr_retired = r_retired;

endmodule
